// File: rtl/tcp_msg_poller_meta_ctrl.sv
// Control FSM for the TCP message-poller metadata path.
// Accepts one message request at a time and commits it to the per-flow
// message-request memory. A flow that is not yet active also gets its active
// bit set and its flowid enqueued. A request for an already-active flow only
// overwrites that flow's memory entry (merge).
//
// Handshake rule used on every interface below: a transfer happens in a cycle
// where val && rdy are both high at the rising edge. Once this block raises a
// val, it holds the val high until the transfer happens or reset. It never
// raises a val again for a transfer that has already completed.
module tcp_msg_poller_meta_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_poller_msg_req_val,
  output logic             poller_src_msg_req_rdy,
  output logic             ctrl_data_store_inputs,
  input  logic             data_ctrl_req_pending,
  output logic             ctrl_msg_req_mem_wr_val,
  input  logic             msg_req_mem_ctrl_wr_rdy,
  output logic             ctrl_active_bitvec_set_req_val,
  input  logic             active_bitvec_ctrl_set_req_rdy,
  output logic             ctrl_msg_req_q_wr_req_val,
  input  logic             msg_req_q_ctrl_wr_req_rdy,
  output logic [CNT_W-1:0] ctrl_enq_cnt,
  output logic [CNT_W-1:0] ctrl_merge_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_WR = 2'd1,
    ST_ENQ    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             q_done_q, q_done_d;
  logic             bv_done_q, bv_done_d;
  logic [CNT_W-1:0] enq_cnt_q, enq_cnt_d;
  logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;

  logic in_idle;
  logic mem_val;
  logic q_val;
  logic bv_val;
  logic req_hs;
  logic mem_hs;
  logic q_hs;
  logic bv_hs;
  logic q_fin;
  logic bv_fin;

  // Raw request strobes. They depend only on the registered state and flags,
  // except for the datapath load strobe, which follows the source val while idle.
  assign in_idle = (state_q == ST_IDLE);
  assign mem_val = (state_q == ST_MEM_WR);
  assign q_val   = (state_q == ST_ENQ) && !q_done_q;
  assign bv_val  = (state_q == ST_ENQ) && !bv_done_q;

  assign req_hs  = in_idle && src_poller_msg_req_val;
  assign mem_hs  = mem_val && msg_req_mem_ctrl_wr_rdy;
  assign q_hs    = q_val && msg_req_q_ctrl_wr_req_rdy;
  assign bv_hs   = bv_val && active_bitvec_ctrl_set_req_rdy;
  assign q_fin   = q_done_q || q_hs;
  assign bv_fin  = bv_done_q || bv_hs;

  // While reset is held, keep all vals low and report ready,
  // even before the state register has been cleared.
  assign poller_src_msg_req_rdy         = !rst_n || in_idle;
  assign ctrl_data_store_inputs         = rst_n && req_hs;
  assign ctrl_msg_req_mem_wr_val        = rst_n && mem_val;
  assign ctrl_msg_req_q_wr_req_val      = rst_n && q_val;
  assign ctrl_active_bitvec_set_req_val = rst_n && bv_val;
  assign ctrl_enq_cnt                   = enq_cnt_q;
  assign ctrl_merge_cnt                 = merge_cnt_q;
  assign dbg_state                      = state_q;

  // Next-state, done-flag and counter logic for one request at a time.
  always_comb begin
    state_d     = state_q;
    q_done_d    = q_done_q;
    bv_done_d   = bv_done_q;
    enq_cnt_d   = enq_cnt_q;
    merge_cnt_d = merge_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (src_poller_msg_req_val) state_d = ST_MEM_WR;
      end
      ST_MEM_WR: begin
        // Pending is sampled when the write is accepted, not when the request
        // arrives. The poller may clear the flow while the write is stalled.
        if (msg_req_mem_ctrl_wr_rdy) begin
          if (data_ctrl_req_pending) begin
            state_d     = ST_IDLE;
            merge_cnt_d = merge_cnt_q + CNT_ONE;
          end else begin
            state_d = ST_ENQ;
          end
        end
      end
      ST_ENQ: begin
        if (q_fin && bv_fin) begin
          state_d   = ST_IDLE;
          q_done_d  = 1'b0;
          bv_done_d = 1'b0;
          enq_cnt_d = enq_cnt_q + CNT_ONE;
        end else begin
          q_done_d  = q_fin;
          bv_done_d = bv_fin;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, flag and counter registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      q_done_q    <= 1'b0;
      bv_done_q   <= 1'b0;
      enq_cnt_q   <= '0;
      merge_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      q_done_q    <= q_done_d;
      bv_done_q   <= bv_done_d;
      enq_cnt_q   <= enq_cnt_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

endmodule

// File: doc/tcp_msg_poller_meta_ctrl.md
Name: tcp_msg_poller_meta_ctrl

Overview:
- Control FSM paired with the TCP message-poller metadata datapath.
- Accepts one message request per handshake from the source and has the datapath capture flowid, length and destination.
- Commits the request to the per-flow message-request memory.
- For a newly active flow only, it also sets the flow's active bit and enqueues the flowid on the message-request queue. A request for an already-active flow just overwrites that flow's memory entry (merge).

Parameters:
CNT_W, 16, width of the enqueue and merge statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
src_poller_msg_req_val  in  1  source request valid
poller_src_msg_req_rdy  out  1  request accepted when val&rdy
ctrl_data_store_inputs  out  1  datapath loads flowid/len/dst registers this cycle
data_ctrl_req_pending  in  1  active bit of the registered flowid (combinational from datapath)
ctrl_msg_req_mem_wr_val  out  1  message-request memory write valid (addr/data from datapath)
msg_req_mem_ctrl_wr_rdy  in  1  memory write accepted
ctrl_active_bitvec_set_req_val  out  1  set active bit for registered flowid
active_bitvec_ctrl_set_req_rdy  in  1  set accepted
ctrl_msg_req_q_wr_req_val  out  1  enqueue registered flowid
msg_req_q_ctrl_wr_req_rdy  in  1  enqueue accepted (deasserted when full)
ctrl_enq_cnt  out  CNT_W  count of new-flow enqueues
ctrl_merge_cnt  out  CNT_W  count of merged (already-pending) requests

Behaviour:
- States: IDLE, MEM_WR, ENQ. On reset: state=IDLE, both done flags=0, both counters=0.
- Outputs during reset and immediately after: every val output is 0; poller_src_msg_req_rdy=1 (IDLE).
- IDLE:
  - rdy=1; ctrl_data_store_inputs = src_poller_msg_req_val.
  - On val, go to MEM_WR.
  - No other output asserted.
- MEM_WR:
  - rdy=0; ctrl_msg_req_mem_wr_val=1; hold until msg_req_mem_ctrl_wr_rdy.
  - data_ctrl_req_pending is sampled live in the acceptance cycle, not at IDLE. This catches a flow that the poller cleared while the write was stalled.
  - Accepted with pending=1: go to IDLE; ctrl_merge_cnt+1.
  - Accepted with pending=0: go to ENQ.
- ENQ:
  - ctrl_msg_req_q_wr_req_val = !q_done; ctrl_active_bitvec_set_req_val = !bv_done. Both are issued in parallel.
  - Each done flag sets on its own handshake.
  - Exit to IDLE in the cycle the last outstanding handshake completes; both completing in the same cycle is legal and exits immediately.
  - On exit: clear both done flags; ctrl_enq_cnt+1.
  - A deasserted val is never reasserted for an already-done handshake.
- Ordering guarantees:
  - The enqueue is never issued before the memory write is accepted, so a dequeuer always reads committed data.
  - The memory write of a later request never precedes the enqueue of an earlier one (single outstanding request).
- Throughput:
  - New flow: 3 cycles minimum per request (IDLE, MEM_WR, ENQ).
  - Merge: 2 cycles minimum.
  - No request is accepted outside IDLE.
- Queue full: remain in ENQ with q val held high. The bitvec set may complete meanwhile and is not repeated.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-operation (rst_n=0 in any state):
  - Next state is IDLE; in-flight request dropped; flags and counters cleared.
  - Any partially completed side effects (memory or bitvec) remain; recovery is the owner's responsibility.
- ctrl_data_store_inputs is never asserted outside IDLE, so datapath registers are stable through MEM_WR and ENQ.

Test Plan:
- Reset, then request flowid 5 with bit 5 clear and all rdys=1 -> rdy pattern 1,0,0,1. Mem write in cycle 2; q and bitvec vals in cycle 3. Result: enq_cnt=1, merge_cnt=0.
- Request flowid 5 with pending=1 -> one mem write, no q/bitvec val, back to IDLE after 2 cycles, merge_cnt=1.
- mem_wr_rdy=0 for 4 cycles, and pending goes 1->0 during the stall -> mem val held for 5 cycles; the 0 seen at acceptance drives the transition to ENQ and enqueue occurs.
- Queue full (q rdy=0) for 3 cycles, bitvec rdy=1 -> bitvec val for 1 cycle only; q val held 4 cycles; exit on q accept; enq_cnt+1.
- Back-to-back: val held high for 300 new-flow requests with CNT_W=8 -> one accept every 3 cycles; enq_cnt wraps to 44.
- rst_n=0 while in ENQ with q stalled -> next cycle state IDLE, rdy=1, all vals 0, counters 0.
